sys_desc_regbank: RTL
=====================

# sys_desc_regbank

Parametrised bank of system descriptor-table registers (IDT, GDT, LDT, TR and optional extras) with per-register and bulk write ports, plus a hardware context stack. The stack saves and restores the whole bank on task switch or nested-interrupt entry and exit. It sits beside the integer register file and feeds descriptor bases to the execute and MMU stages. It supersedes the fixed 4×64-bit all-or-nothing system register.

## Interface
- WIDTH, 64, bits per system register
- NREG, 4, number of registers: index 0 IDT, 1 GDT, 2 LDT, 3 TR, ≥4 implementation-defined
- IDXW, 2, width of register index; must satisfy 2^IDXW ≥ NREG
- DEPTH, 4, context stack entries (≥1)
- LVLW, 3, width of level output; must hold 0..DEPTH
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- we  in  1  single-register write strobe
- widx  in  IDXW  target register of we
- wdata  in  WIDTH  data for we
- bulk_we  in  1  write all registers
- bulk_data  in  NREG*WIDTH  register i at bits [i*WIDTH +: WIDTH]
- push  in  1  save current bank onto stack
- pop  in  1  restore bank from top of stack
- lock_i  in  NREG  per-register lock set requests; only effective with SYSREG_LOCK_EN
- regs_o  out  NREG*WIDTH  current register values, same packing as bulk_data
- level  out  LVLW  stack occupancy
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- locked_o  out  NREG  lock state
- err  out  1  one-cycle pulse on any rejected request

## Operation
- All state is updated on posedge clk. Reset values: regs_o 0, level 0, empty 1, full 0, locked_o 0, err 0. Stack contents after reset are don't-care.
- Bank update priority, highest first:
  - pop: restore all NREG registers from the top entry, then level−1.
  - bulk_we: write all registers.
  - we: write register widx.
  - A lower-priority write in the same cycle as a higher-priority one is dropped silently, with no err.
- push: copies the pre-edge regs_o into entry[level], then level+1. On push with any write in the same cycle, the stack holds the old values and the bank takes the new ones.
- Error cases. Each raises err for exactly the next cycle; state is otherwise unchanged for the offending request, and other valid requests that cycle still execute:
  - push while full.
  - pop while empty.
  - push and pop together. Both are rejected, and any write in that cycle still applies.
  - we with widx ≥ NREG.
  - A write to a locked register (lock build only).
- Stack is LIFO. level moves by at most 1 per cycle. full and empty are derived from the registered level.
- Reset mid-operation clears everything, including any in-flight push or pop request in that cycle.

## Timing
- Write latency: 1 cycle. A value written at edge N is visible on regs_o after edge N. There is no combinational path from any input to regs_o.
- push/pop: level, full and empty reflect the operation after the same edge. A pop result appears on regs_o after that edge.
- err is registered: asserted the cycle after the offending request, deasserted the following cycle unless a new error occurs.
- Back-to-back push/pop on consecutive cycles is supported with no bubbles.

## Configuration
- SYSREG_LOCK_EN defined:
  - lock_i[i]=1 sets locked_o[i] sticky until rst.
  - we or bulk_we to a locked register leaves it unchanged and raises err. Bulk still writes the unlocked registers.
  - pop restores locked registers anyway; it is the trusted hardware path.
  - A lock set in the same cycle as a write to that register lets the write complete first.
- SYSREG_LOCK_EN undefined: lock_i ignored, locked_o tied 0, no lock-related err.

## Test plan
- Reset then we=1, widx=1, wdata=64'h1234 → regs_o[GDT]=64'h1234 one cycle later; other registers 0; err 0.
- bulk_we together with we → bulk values win; we dropped; err 0.
- Push bank A; bulk-write bank B; push; pop; pop → regs_o=B after first pop, A after second; level 2→1→0; empty=1 at end.
- DEPTH pushes then a fifth push (DEPTH=4) → full=1, level=4, err pulses 1 cycle, stack unchanged. Pop on empty → err pulse, regs_o unchanged.
- Push with we (widx=0, wdata=64'hAA) from IDT=0 → IDT=64'hAA; a later pop restores IDT=0. push+pop in the same cycle → err pulse, level unchanged.
- SYSREG_LOCK_EN: lock_i=4'b0100, then we to LDT with 64'h55 → LDT unchanged, err pulse; pop of a saved entry still overwrites LDT; rst clears locked_o to 0.

Source files
------------

// File: rtl/sys_desc_regbank.sv
// Descriptor-table register bank (IDT, GDT, LDT, TR, extras) with a LIFO context stack.
// Register locking is compiled in only when SYSREG_LOCK_EN is defined.
module sys_desc_regbank #(
  parameter int WIDTH = 64,
  parameter int NREG  = 4,
  parameter int IDXW  = 2,
  parameter int DEPTH = 4,
  parameter int LVLW  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDXW-1:0]       widx,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  bulk_we,
  input  logic [NREG*WIDTH-1:0] bulk_data,
  input  logic                  push,
  input  logic                  pop,
  input  logic [NREG-1:0]       lock_i,
  output logic [NREG*WIDTH-1:0] regs_o,
  output logic [LVLW-1:0]       level,
  output logic                  full,
  output logic                  empty,
  output logic [NREG-1:0]       locked_o,
  output logic                  err
);

  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]      regs_reg  [NREG];
  logic [WIDTH-1:0]      regs_next [NREG];
  logic [NREG*WIDTH-1:0] stack_mem [DEPTH];
  logic [NREG*WIDTH-1:0] top_entry;
  logic [LVLW-1:0]       level_reg, level_next;
  logic [NREG-1:0]       locked_reg, locked_next, lock_mask;
  logic                  err_reg, err_next;
  logic                  push_ok, pop_ok, widx_hit;
  logic [SW-1:0]         push_ptr, pop_ptr;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_out
      assign regs_o[gi*WIDTH +: WIDTH] = regs_reg[gi];
    end
  endgenerate

  assign level    = level_reg;
  assign full     = (level_reg == LVLW'(DEPTH));
  assign empty    = (level_reg == '0);
  assign locked_o = locked_reg;
  assign err      = err_reg;

  // push and pop together cancel each other; both are reported as an error
  assign push_ok   = push & ~pop & ~full;
  assign pop_ok    = pop & ~push & ~empty;
  assign push_ptr  = SW'(level_reg);
  assign pop_ptr   = SW'(level_reg - LVLW'(1));
  assign top_entry = stack_mem[pop_ptr];

`ifdef SYSREG_LOCK_EN
  // Locks act on the pre-edge state, so a write landing with its lock still completes
  assign lock_mask   = locked_reg;
  assign locked_next = locked_reg | lock_i;
`else
  logic unused_lock;
  assign unused_lock = ^lock_i;
  assign lock_mask   = '0;
  assign locked_next = '0;
`endif

  always_comb begin
    regs_next  = regs_reg;
    level_next = level_reg;
    widx_hit   = 1'b0;
    err_next   = (push & pop) | (push & ~pop & full) | (pop & ~push & empty);
    if (push_ok) level_next = level_reg + LVLW'(1);
    if (pop_ok)  level_next = level_reg - LVLW'(1);
    if (pop_ok) begin
      // restore ignores locks: the stack is the trusted save path
      for (int i = 0; i < NREG; i++) regs_next[i] = top_entry[i*WIDTH +: WIDTH];
    end else if (bulk_we) begin
      for (int i = 0; i < NREG; i++) begin
        if (lock_mask[i]) err_next = 1'b1;
        else              regs_next[i] = bulk_data[i*WIDTH +: WIDTH];
      end
    end else if (we) begin
      for (int i = 0; i < NREG; i++) begin
        if (widx == IDXW'(i)) begin
          widx_hit = 1'b1;
          if (lock_mask[i]) err_next = 1'b1;
          else              regs_next[i] = wdata;
        end
      end
      if (!widx_hit) err_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_reg[i] <= '0;
      level_reg  <= '0;
      locked_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      regs_reg   <= regs_next;
      level_reg  <= level_next;
      locked_reg <= locked_next;
      err_reg    <= err_next;
    end
  end

  // Stack entries are not reset; they are only readable once pushed
  always_ff @(posedge clk) begin
    if (!rst && push_ok) stack_mem[push_ptr] <= regs_o;
  end

endmodule
